// File: rtl/scan_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_player_pkg
//  Description : Shared types and helpers for the scan pattern player. This
//                file holds the FSM state encoding, the length of the
//                scan-mode setup window and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_player_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Cycles spent with Test_Mode/Test_Se settled before the first shift.
    localparam int SETUP_CYCLES = 2;

    // Increments value and saturates at (2**width)-1. Callers zero-extend
    // their counter to 32 bits on the way in and truncate on the way out.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] w_max;
        w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= w_max) ? w_max : (value + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_compare_unit.sv
`default_nettype none
// ============================================================================
//  Module      : scan_compare_unit
//  Description : Masked scan-out comparator. Flags a failing vector when any
//                masked chain differs from its expected bit, keeps a
//                saturating per-vector miscompare count and latches the
//                location of the first failure.
//  Ports       : clk/rst          - clock, synchronous active-high reset
//                i_clear          - clears count and first-fail record
//                i_en             - a vector is being accepted this cycle
//                i_so/i_exp/i_mask- scan-out, expected and compare mask
//                i_pat/i_vec      - pattern / shift index of this vector
//                o_err_count      - saturating failing-vector count
//                o_ff_*           - first failure valid/pattern/vector/chains
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_compare_unit
    import scan_player_pkg::*;
#(
    parameter int NCHAINS = 4,
    parameter int LEN_W   = 16,
    parameter int PAT_W   = 16,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [NCHAINS-1:0] i_so,
    input  logic [NCHAINS-1:0] i_exp,
    input  logic [NCHAINS-1:0] i_mask,
    input  logic [PAT_W-1:0]   i_pat,
    input  logic [LEN_W-1:0]   i_vec,
    output logic [ERR_W-1:0]   o_err_count,
    output logic               o_ff_valid,
    output logic [PAT_W-1:0]   o_ff_pat,
    output logic [LEN_W-1:0]   o_ff_vec,
    output logic [NCHAINS-1:0] o_ff_chain
);

    logic [NCHAINS-1:0] w_diff;
    logic               w_fail;
    logic [ERR_W-1:0]   r_err;
    logic               r_ff_valid;
    logic [PAT_W-1:0]   r_ff_pat;
    logic [LEN_W-1:0]   r_ff_vec;
    logic [NCHAINS-1:0] r_ff_chain;

    assign w_diff = (i_so ^ i_exp) & i_mask;
    // One failing vector counts once, however many chains disagree.
    assign w_fail = i_en & (|w_diff);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_pat   <= '0;
            r_ff_vec   <= '0;
            r_ff_chain <= '0;
        end else if (w_fail) begin
            r_err <= ERR_W'(sat_inc(32'(r_err), ERR_W));
            if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_pat   <= i_pat;
                r_ff_vec   <= i_vec;
                r_ff_chain <= w_diff;
            end
        end
    end

    assign o_err_count = r_err;
    assign o_ff_valid  = r_ff_valid;
    assign o_ff_pat    = r_ff_pat;
    assign o_ff_vec    = r_ff_vec;
    assign o_ff_chain  = r_ff_chain;

endmodule
`default_nettype wire

// File: rtl/scan_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pattern_player
//  Description : Replays a streamed scan pattern set into an N-chain
//                scan-inserted core and compares its scan-out against masked
//                expected data. Each shift block loads pattern p while
//                unloading pattern p-1; the block after the last capture is
//                unload-only.
//  Ports       : hclk/hreset        - clock, synchronous active-high reset
//                start/abort        - run control pulses
//                cfg_chain_len/num  - shifts per block, patterns per run
//                pat_*              - valid/ready pattern stream
//                Test_Mode/Test_Se/scan_clk_en/si/so - core scan interface
//                busy/done          - run status
//                pattern_number/vector_number - run position
//                err_count/first_fail_*       - miscompare results
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_pattern_player
    import scan_player_pkg::*;
#(
    parameter int NCHAINS        = 4,
    parameter int LEN_W          = 16,
    parameter int PAT_W          = 16,
    parameter int ERR_W          = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   cfg_chain_len,
    input  logic [PAT_W-1:0]   cfg_num_pat,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [NCHAINS-1:0] pat_si,
    input  logic [NCHAINS-1:0] pat_exp,
    input  logic [NCHAINS-1:0] pat_mask,
    output logic               Test_Mode,
    output logic               Test_Se,
    output logic               scan_clk_en,
    output logic [NCHAINS-1:0] si,
    input  logic [NCHAINS-1:0] so,
    output logic               busy,
    output logic               done,
    output logic [PAT_W-1:0]   pattern_number,
    output logic [LEN_W-1:0]   vector_number,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_fail_valid,
    output logic [PAT_W-1:0]   first_fail_pat,
    output logic [LEN_W-1:0]   first_fail_vec,
    output logic [NCHAINS-1:0] first_fail_chain
);

    localparam logic [1:0] c_setup_last   = 2'(SETUP_CYCLES - 1);
    localparam logic [1:0] c_capture_last = 2'(CAPTURE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [PAT_W-1:0]   r_num_pat;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_vec;
    logic [1:0]         r_cnt;
    logic [NCHAINS-1:0] r_si;

    logic               w_start;
    logic               w_accept;
    logic               w_last_vec;
    logic               w_run_end;
    logic [PAT_W-1:0]   w_unload_pat;

    assign w_start    = (r_state == IDLE) & start;
    assign w_accept   = (r_state == SHIFT) & pat_valid;
    assign w_last_vec = (r_vec == (r_len - LEN_W'(1)));
    assign w_run_end  = (r_pat == r_num_pat);

    // The block being shifted unloads the previous pattern; the very first
    // load has no predecessor and is reported as pattern 0.
    assign w_unload_pat = (r_pat == '0) ? '0 : (r_pat - PAT_W'(1));

    // ------------------------------------------------------------------
    // State register and run counters
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_num_pat <= '0;
            r_pat     <= '0;
            r_vec     <= '0;
            r_cnt     <= '0;
            r_si      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Shared dwell counter for SETUP and CAPTURE; restarts on every
            // state change so each window is timed from its first cycle.
            r_cnt   <= (w_state_nxt != r_state) ? 2'd0 : (r_cnt + 2'd1);

            if (w_start) begin
                r_len     <= cfg_chain_len;
                r_num_pat <= cfg_num_pat;
                r_pat     <= '0;
                r_vec     <= '0;
                r_si      <= '0;
            end

            if (w_accept) begin
                r_vec <= r_vec + LEN_W'(1);
                r_si  <= pat_si;
            end

            if ((r_state == CAPTURE) && (w_state_nxt == SHIFT)) begin
                r_pat <= r_pat + PAT_W'(1);
                r_vec <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SETUP;
            end
            SETUP: begin
                if (abort)                      w_state_nxt = DONE;
                else if (r_cnt == c_setup_last) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort)                       w_state_nxt = DONE;
                else if (w_accept && w_last_vec) w_state_nxt = w_run_end ? DONE : CAPTURE;
            end
            CAPTURE: begin
                if (abort)                        w_state_nxt = DONE;
                else if (r_cnt == c_capture_last) w_state_nxt = SHIFT;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan interface and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        pat_ready   = 1'b0;
        Test_Mode   = 1'b0;
        Test_Se     = 1'b0;
        scan_clk_en = 1'b0;
        si          = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            SETUP: begin
                Test_Mode = 1'b1;
                Test_Se   = 1'b1;
                busy      = 1'b1;
            end
            SHIFT: begin
                Test_Mode   = 1'b1;
                Test_Se     = 1'b1;
                busy        = 1'b1;
                pat_ready   = 1'b1;
                scan_clk_en = pat_valid;
                // During a stall the last shifted bit stays on si.
                si          = pat_valid ? pat_si : r_si;
            end
            CAPTURE: begin
                Test_Mode   = 1'b1;
                busy        = 1'b1;
                scan_clk_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                pat_ready = 1'b0;
            end
        endcase
    end

    assign pattern_number = r_pat;
    assign vector_number  = r_vec;

    scan_compare_unit #(
        .NCHAINS (NCHAINS),
        .LEN_W   (LEN_W),
        .PAT_W   (PAT_W),
        .ERR_W   (ERR_W)
    ) u_cmp (
        .clk         (hclk),
        .rst         (hreset),
        .i_clear     (w_start),
        .i_en        (w_accept),
        .i_so        (so),
        .i_exp       (pat_exp),
        .i_mask      (pat_mask),
        .i_pat       (w_unload_pat),
        .i_vec       (r_vec),
        .o_err_count (err_count),
        .o_ff_valid  (first_fail_valid),
        .o_ff_pat    (first_fail_pat),
        .o_ff_vec    (first_fail_vec),
        .o_ff_chain  (first_fail_chain)
    );

endmodule
`default_nettype wire

// File: tb/tb_scan_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_pattern_player
//  Description : Self-checking bench for scan_pattern_player. A second
//                instance with a 2-bit error counter shares all inputs so
//                saturation can be observed alongside the full-width count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_pattern_player;

    localparam int NCH  = 4;
    localparam int LW   = 16;
    localparam int PW   = 16;
    localparam int EW   = 16;
    localparam int CAPC = 1;

    logic            hclk = 1'b0;
    logic            hreset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [LW-1:0]   cfg_chain_len = '0;
    logic [PW-1:0]   cfg_num_pat = '0;
    logic            pat_valid = 1'b0;
    logic [NCH-1:0]  pat_si = '0;
    logic [NCH-1:0]  pat_exp = '0;
    logic [NCH-1:0]  pat_mask = '0;
    logic [NCH-1:0]  so = '0;

    logic            pat_ready, Test_Mode, Test_Se, scan_clk_en, busy, done;
    logic [NCH-1:0]  si, first_fail_chain;
    logic [PW-1:0]   pattern_number, first_fail_pat;
    logic [LW-1:0]   vector_number, first_fail_vec;
    logic [EW-1:0]   err_count;
    logic            first_fail_valid;

    logic            d2_pat_ready, d2_Test_Mode, d2_Test_Se, d2_scan_clk_en, d2_busy, d2_done;
    logic [NCH-1:0]  d2_si, d2_ff_chain;
    logic [PW-1:0]   d2_pattern_number, d2_ff_pat;
    logic [LW-1:0]   d2_vector_number, d2_ff_vec;
    logic [1:0]      d2_err_count;
    logic            d2_ff_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Pattern stream and model results
    logic [NCH-1:0] v_si [0:255];
    logic [NCH-1:0] v_exp[0:255];
    logic [NCH-1:0] v_msk[0:255];
    logic [NCH-1:0] v_so [0:255];
    int             total;
    int             m_err, m_err2, m_ffpat, m_ffvec;
    logic           m_ffv;
    logic [NCH-1:0] m_ffchain;

    // Observations from the last run
    int             o_accepts, o_done_cyc, o_caps, o_bad, o_stall_cyc, o_stall_bad;
    logic           o_done_tm, o_done_se, o_done_busy, o_ffv;
    logic [EW-1:0]  o_err;
    logic [1:0]     o_err2;
    logic [PW-1:0]  o_ffpat;
    logic [LW-1:0]  o_ffvec;
    logic [NCH-1:0] o_ffchain;

    always #5 hclk = ~hclk;

    scan_pattern_player #(.NCHAINS(NCH), .LEN_W(LW), .PAT_W(PW), .ERR_W(EW), .CAPTURE_CYCLES(CAPC)) dut (
        .hclk(hclk), .hreset(hreset), .start(start), .abort(abort),
        .cfg_chain_len(cfg_chain_len), .cfg_num_pat(cfg_num_pat),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_si(pat_si), .pat_exp(pat_exp), .pat_mask(pat_mask),
        .Test_Mode(Test_Mode), .Test_Se(Test_Se), .scan_clk_en(scan_clk_en), .si(si), .so(so),
        .busy(busy), .done(done), .pattern_number(pattern_number), .vector_number(vector_number),
        .err_count(err_count), .first_fail_valid(first_fail_valid), .first_fail_pat(first_fail_pat),
        .first_fail_vec(first_fail_vec), .first_fail_chain(first_fail_chain)
    );

    scan_pattern_player #(.NCHAINS(NCH), .LEN_W(LW), .PAT_W(PW), .ERR_W(2), .CAPTURE_CYCLES(CAPC)) dut2 (
        .hclk(hclk), .hreset(hreset), .start(start), .abort(abort),
        .cfg_chain_len(cfg_chain_len), .cfg_num_pat(cfg_num_pat),
        .pat_valid(pat_valid), .pat_ready(d2_pat_ready), .pat_si(pat_si), .pat_exp(pat_exp), .pat_mask(pat_mask),
        .Test_Mode(d2_Test_Mode), .Test_Se(d2_Test_Se), .scan_clk_en(d2_scan_clk_en), .si(d2_si), .so(so),
        .busy(d2_busy), .done(d2_done), .pattern_number(d2_pattern_number), .vector_number(d2_vector_number),
        .err_count(d2_err_count), .first_fail_valid(d2_ff_valid), .first_fail_pat(d2_ff_pat),
        .first_fail_vec(d2_ff_vec), .first_fail_chain(d2_ff_chain)
    );

    // mode 0: masks only on the unload-only block, so == exp
    // mode 1: random masks, occasional random corruption of so
    // mode 2: every vector fully masked and every chain wrong
    task automatic build_stream(input int L, input int N, input int mode);
        total = (N + 1) * L;
        for (int k = 0; k < total; k++) begin
            v_si[k]  = NCH'($urandom);
            v_exp[k] = NCH'($urandom);
            case (mode)
                0: begin v_msk[k] = (k >= N * L) ? '1 : '0; v_so[k] = v_exp[k]; end
                1: begin
                    v_msk[k] = NCH'($urandom);
                    v_so[k]  = v_exp[k] ^ (($urandom_range(0, 3) == 0) ? NCH'($urandom) : NCH'(0));
                end
                default: begin v_msk[k] = '1; v_so[k] = ~v_exp[k]; end
            endcase
        end
    endtask

    // Reference: count failing vectors among the first n_vec of the stream;
    // vector k sits in block k/L at shift k%L and unloads pattern k/L-1.
    task automatic model(input int L, input int n_vec);
        logic [NCH-1:0] d;
        m_err = 0; m_ffv = 1'b0; m_ffpat = 0; m_ffvec = 0; m_ffchain = '0;
        for (int k = 0; k < n_vec; k++) begin
            d = (v_so[k] ^ v_exp[k]) & v_msk[k];
            if (d != '0) begin
                m_err++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffpat = (k / L == 0) ? 0 : (k / L - 1);
                    m_ffvec = k % L;
                    m_ffchain = d;
                end
            end
        end
        m_err2 = (m_err > 3) ? 3 : m_err;
    endtask

    // Drives one run from the stream arrays and records what was observed.
    task automatic run_stream(input int L, input int N, input int stall_at, input int stall_len, input int abort_at);
        int   idx, stall_n;
        logic acc, stalled;
        idx = 0; stall_n = 0;
        o_accepts = 0; o_done_cyc = -1; o_caps = 0; o_bad = 0; o_stall_cyc = 0; o_stall_bad = 0;
        @(posedge hclk); #1;
        cfg_chain_len = LW'(L); cfg_num_pat = PW'(N); start = 1'b1;
        for (int cyc = 0; cyc < 4000 && o_done_cyc < 0; cyc++) begin
            stalled = (idx == stall_at) && pat_ready && (stall_n < stall_len);
            if (stalled) begin stall_n++; o_stall_cyc++; end
            pat_valid = (idx < total) && !stalled;
            pat_si    = (idx < total) ? v_si[idx]  : '0;
            pat_exp   = (idx < total) ? v_exp[idx] : '0;
            pat_mask  = (idx < total) ? v_msk[idx] : '0;
            so        = (idx < total) ? v_so[idx]  : '0;
            abort     = pat_valid && pat_ready && (idx == abort_at);
            @(negedge hclk);
            acc = pat_valid && pat_ready;
            if (acc) begin
                o_accepts++;
                if (si !== pat_si || scan_clk_en !== 1'b1 || vector_number !== LW'(idx % L)
                    || pattern_number !== PW'(idx / L) || Test_Se !== 1'b1) o_bad++;
            end
            if (stalled && (scan_clk_en !== 1'b0 || Test_Se !== 1'b1 || vector_number !== LW'(idx % L)))
                o_stall_bad++;
            if (busy && !Test_Se) begin
                o_caps++;
                if (scan_clk_en !== 1'b1 || pat_ready !== 1'b0) o_bad++;
            end
            if (done) begin
                o_done_cyc = cyc; o_done_tm = Test_Mode; o_done_se = Test_Se; o_done_busy = busy;
                o_err = err_count; o_err2 = d2_err_count; o_ffv = first_fail_valid;
                o_ffpat = first_fail_pat; o_ffvec = first_fail_vec; o_ffchain = first_fail_chain;
            end
            @(posedge hclk); #1;
            start = 1'b0; abort = 1'b0;
            if (acc) idx++;
        end
        pat_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        n_checks++;
        if ({pat_ready, Test_Mode, Test_Se, scan_clk_en, si, busy, done, pattern_number, vector_number,
             err_count, first_fail_valid, first_fail_pat, first_fail_vec, first_fail_chain} !== '0)
            $display("FAIL reset_outputs: some output nonzero (busy=%b tm=%b err=%0d), want all 0", busy, Test_Mode, err_count);
        else n_pass++;
        hreset = 1'b0;
        @(posedge hclk); #1 abort = 1'b1;
        @(posedge hclk); #1 abort = 1'b0;
        @(negedge hclk);
        n_checks++;
        if ({busy, done, Test_Mode} !== 3'b000) $display("FAIL idle_abort: busy/done/tm=%b want 000", {busy, done, Test_Mode});
        else n_pass++;
    endtask

    task automatic test_clean_run;
        build_stream(3, 1, 0);
        model(3, total);
        run_stream(3, 1, -1, 0, -1);
        n_checks++; if (o_done_cyc !== 10) $display("FAIL clean_done_cycle: got %0d want 10", o_done_cyc); else n_pass++;
        n_checks++; if (o_accepts !== 6) $display("FAIL clean_accepts: got %0d want 6", o_accepts); else n_pass++;
        n_checks++; if (o_caps !== 1) $display("FAIL clean_se_low_cycles: got %0d want 1", o_caps); else n_pass++;
        n_checks++; if (o_bad !== 0) $display("FAIL clean_shift_protocol: got %0d bad cycles want 0", o_bad); else n_pass++;
        n_checks++; if (o_err !== EW'(0) || o_ffv !== 1'b0) $display("FAIL clean_errors: err=%0d ffv=%b want 0/0", o_err, o_ffv); else n_pass++;
        n_checks++; if ({o_done_tm, o_done_se} !== 2'b00) $display("FAIL clean_done_scan: tm/se=%b want 00", {o_done_tm, o_done_se}); else n_pass++;
        @(negedge hclk);
        n_checks++; if ({done, busy} !== 2'b00) $display("FAIL clean_done_pulse: done/busy=%b want 00", {done, busy}); else n_pass++;
        n_checks++; if (err_count !== EW'(0)) $display("FAIL clean_err_hold: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_single_fail;
        build_stream(3, 1, 0);
        v_so[4] = v_so[4] ^ 4'b0100;
        run_stream(3, 1, -1, 0, -1);
        n_checks++; if (o_err !== EW'(1)) $display("FAIL single_err: got %0d want 1", o_err); else n_pass++;
        n_checks++; if (o_ffv !== 1'b1 || o_ffpat !== PW'(0)) $display("FAIL single_ff_pat: v=%b pat=%0d want 1/0", o_ffv, o_ffpat); else n_pass++;
        n_checks++; if (o_ffvec !== LW'(1)) $display("FAIL single_ff_vec: got %0d want 1", o_ffvec); else n_pass++;
        n_checks++; if (o_ffchain !== 4'b0100) $display("FAIL single_ff_chain: got %b want 0100", o_ffchain); else n_pass++;
        @(negedge hclk);
        n_checks++; if (first_fail_vec !== LW'(1) || err_count !== EW'(1)) $display("FAIL single_hold: vec=%0d err=%0d want 1/1", first_fail_vec, err_count); else n_pass++;
    endtask

    task automatic test_stall;
        build_stream(4, 2, 1);
        model(4, total);
        run_stream(4, 2, 5, 5, -1);
        n_checks++; if (o_done_cyc !== 3 + 12 + 2 * CAPC + 5) $display("FAIL stall_done_cycle: got %0d want %0d", o_done_cyc, 3 + 12 + 2 * CAPC + 5); else n_pass++;
        n_checks++; if (o_stall_cyc !== 5 || o_stall_bad !== 0) $display("FAIL stall_hold: stalls=%0d bad=%0d want 5/0", o_stall_cyc, o_stall_bad); else n_pass++;
        n_checks++; if (o_accepts !== 12 || o_bad !== 0) $display("FAIL stall_accepts: acc=%0d bad=%0d want 12/0", o_accepts, o_bad); else n_pass++;
        n_checks++; if (o_err !== EW'(m_err)) $display("FAIL stall_err: got %0d want %0d", o_err, m_err); else n_pass++;
        n_checks++; if (o_ffchain !== m_ffchain || o_ffvec !== LW'(m_ffvec)) $display("FAIL stall_ff: chain=%b vec=%0d want %b/%0d", o_ffchain, o_ffvec, m_ffchain, m_ffvec); else n_pass++;
    endtask

    task automatic test_saturate;
        build_stream(3, 2, 2);
        model(3, total);
        run_stream(3, 2, -1, 0, -1);
        n_checks++; if (o_err2 !== 2'(m_err2)) $display("FAIL sat_err2: got %0d want %0d", o_err2, m_err2); else n_pass++;
        n_checks++; if (o_err !== EW'(m_err)) $display("FAIL sat_err_full: got %0d want %0d", o_err, m_err); else n_pass++;
        n_checks++; if (o_ffpat !== PW'(0) || o_ffvec !== LW'(0) || o_ffchain !== 4'hF)
            $display("FAIL sat_first_fail: pat=%0d vec=%0d chain=%b want 0/0/1111", o_ffpat, o_ffvec, o_ffchain); else n_pass++;
        n_checks++; if (d2_ff_chain !== 4'hF || d2_ff_valid !== 1'b1) $display("FAIL sat_d2_ff: chain=%b v=%b want 1111/1", d2_ff_chain, d2_ff_valid); else n_pass++;
    endtask

    task automatic test_abort;
        build_stream(4, 2, 0);
        v_msk[1] = '1; v_so[1] = ~v_exp[1];
        run_stream(4, 2, -1, 0, 1);
        n_checks++; if (o_done_cyc !== 5) $display("FAIL abort_done_cycle: got %0d want 5", o_done_cyc); else n_pass++;
        n_checks++; if (o_accepts !== 2) $display("FAIL abort_accepts: got %0d want 2", o_accepts); else n_pass++;
        n_checks++; if ({o_done_tm, o_done_se, o_done_busy} !== 3'b000) $display("FAIL abort_done_outputs: tm/se/busy=%b want 000", {o_done_tm, o_done_se, o_done_busy}); else n_pass++;
        n_checks++; if (o_err !== EW'(1) || o_ffvec !== LW'(1) || o_ffchain !== 4'hF)
            $display("FAIL abort_compare: err=%0d vec=%0d chain=%b want 1/1/1111", o_err, o_ffvec, o_ffchain); else n_pass++;
    endtask

    task automatic test_reset_in_capture;
        logic found;
        int   dones;
        found = 1'b0; dones = 0;
        @(posedge hclk); #1;
        cfg_chain_len = LW'(2); cfg_num_pat = PW'(2); start = 1'b1;
        pat_valid = 1'b1; pat_mask = '1; pat_exp = NCH'($urandom); so = ~pat_exp; pat_si = NCH'($urandom);
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge hclk);
            if (Test_Mode && !Test_Se) found = 1'b1;
            else begin @(posedge hclk); #1 start = 1'b0; end
        end
        start = 1'b0;
        n_checks++; if (found !== 1'b1) $display("FAIL rst_cap_reach: capture seen=%b want 1", found); else n_pass++;
        n_checks++; if (err_count !== EW'(2)) $display("FAIL rst_cap_pre_err: got %0d want 2", err_count); else n_pass++;
        hreset = 1'b1;
        @(posedge hclk); #1 hreset = 1'b0; pat_valid = 1'b0;
        @(negedge hclk);
        n_checks++;
        if ({pat_ready, Test_Mode, Test_Se, scan_clk_en, si, busy, done, pattern_number, vector_number,
             err_count, first_fail_valid, first_fail_pat, first_fail_vec, first_fail_chain} !== '0)
            $display("FAIL rst_cap_outputs: busy=%b tm=%b err=%0d ffv=%b, want all 0", busy, Test_Mode, err_count, first_fail_valid);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (done || busy) dones++;
            @(negedge hclk);
        end
        n_checks++; if (dones !== 0) $display("FAIL rst_cap_no_done: got %0d done/busy cycles want 0", dones); else n_pass++;
        build_stream(2, 2, 1);
        model(2, total);
        run_stream(2, 2, -1, 0, -1);
        n_checks++; if (o_done_cyc !== 3 + 6 + 2 * CAPC) $display("FAIL rst_rerun_done: got %0d want %0d", o_done_cyc, 3 + 6 + 2 * CAPC); else n_pass++;
        n_checks++; if (o_err !== EW'(m_err) || o_ffv !== m_ffv) $display("FAIL rst_rerun_err: err=%0d ffv=%b want %0d/%b", o_err, o_ffv, m_err, m_ffv); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int L, N;
        for (int it = 0; it < 5; it++) begin
            L = $urandom_range(1, 5);
            N = $urandom_range(1, 3);
            build_stream(L, N, 1);
            model(L, total);
            run_stream(L, N, -1, 0, -1);
            n_checks++; if (o_done_cyc !== 3 + total + N * CAPC || o_accepts !== total || o_bad !== 0)
                $display("FAIL b2b_timing L=%0d N=%0d: done=%0d acc=%0d bad=%0d want %0d/%0d/0", L, N, o_done_cyc, o_accepts, o_bad, 3 + total + N * CAPC, total); else n_pass++;
            n_checks++; if (o_err !== EW'(m_err) || o_err2 !== 2'(m_err2))
                $display("FAIL b2b_err L=%0d N=%0d: err=%0d err2=%0d want %0d/%0d", L, N, o_err, o_err2, m_err, m_err2); else n_pass++;
            n_checks++; if (o_ffv !== m_ffv || o_ffpat !== PW'(m_ffpat) || o_ffvec !== LW'(m_ffvec) || o_ffchain !== m_ffchain)
                $display("FAIL b2b_ff L=%0d N=%0d: v=%b pat=%0d vec=%0d chain=%b want %b/%0d/%0d/%b", L, N, o_ffv, o_ffpat, o_ffvec, o_ffchain, m_ffv, m_ffpat, m_ffvec, m_ffchain); else n_pass++;
            n_checks++; if (o_caps !== N * CAPC) $display("FAIL b2b_captures L=%0d N=%0d: got %0d want %0d", L, N, o_caps, N * CAPC); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_clean_run;
        test_single_fail;
        test_stall;
        test_saturate;
        test_abort;
        test_reset_in_capture;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_pattern_player.md
Name: scan_pattern_player

Overview:
- On-chip, synthesizable successor to the DPV scan testbench flow.
- Replays a streamed scan pattern set into an N-chain scan-inserted core (Test_Mode/Test_Se/si*/so*) and compares scan-out against masked expected data.
- Tracks pattern and vector numbers, counts miscompares and records the first failure.
- Sits between a pattern buffer (valid/ready stream) and the DUT scan ports; the chain count and lengths are parametrised.

Parameters:
- NCHAINS, 4, number of scan chains driven in parallel
- LEN_W, 16, width of chain-length and shift counters
- PAT_W, 16, width of pattern counter
- ERR_W, 16, width of saturating miscompare counter
- CAPTURE_CYCLES, 1, capture clock-enable pulses per pattern (1..4)

Ports:
- hclk  in  1  single clock, all logic rising-edge
- hreset  in  1  synchronous active-high reset
- start  in  1  1-cycle pulse, begins a run when idle
- abort  in  1  1-cycle pulse, terminates the run
- cfg_chain_len  in  LEN_W  shifts per load/unload (>=1), sampled at start
- cfg_num_pat  in  PAT_W  patterns in the run (>=1), sampled at start
- pat_valid  in  1  stream vector valid
- pat_ready  out  1  stream vector accepted when valid&ready
- pat_si  in  NCHAINS  load bit per chain
- pat_exp  in  NCHAINS  expected unload bit per chain
- pat_mask  in  NCHAINS  1 = compare this chain this vector
- Test_Mode  out  1  scan mode to the DUT
- Test_Se  out  1  scan enable
- scan_clk_en  out  1  DUT clock enable (shift or capture edge)
- si  out  NCHAINS  scan-in bits
- so  in  NCHAINS  scan-out bits from the DUT
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at run end (normal or abort)
- pattern_number  out  PAT_W  current pattern
- vector_number  out  LEN_W  shift index within the current load/unload
- err_count  out  ERR_W  saturating miscompare count
- first_fail_valid  out  1  first failure recorded
- first_fail_pat  out  PAT_W  pattern of the first failure
- first_fail_vec  out  LEN_W  shift index of the first failure
- first_fail_chain  out  NCHAINS  failing chain bitmap at the first failure

Behaviour:
- Reset (and idle) values: all outputs 0; the FSM is in IDLE.
- FSM:
  - IDLE -> SETUP on start; latch the config, clear all counters and first_fail.
  - SETUP: Test_Mode=1, Test_Se=1, scan_clk_en=0 for 2 cycles -> SHIFT.
  - SHIFT:
    - pat_ready=1. On each accept: scan_clk_en=1, si=pat_si, and compare so against pat_exp in the same cycle.
    - A miscompare is ((so^pat_exp)&pat_mask)!=0.
    - vector_number increments per accept.
    - No valid: scan_clk_en=0, Test_Se held 1, outputs held (stall).
    - After the cfg_chain_len-th accept -> CAPTURE, or -> DONE if pattern_number==cfg_num_pat.
  - CAPTURE:
    - pat_ready=0, Test_Se=0, scan_clk_en=1 for CAPTURE_CYCLES cycles.
    - Then pattern_number++, vector_number=0, Test_Se=1 -> SHIFT (unload of p overlaps load of p+1).
  - DONE: done=1 for one cycle, Test_Mode=0, Test_Se=0 -> IDLE. The counters and first_fail hold until the next start.
- The stream carries (cfg_num_pat+1)*cfg_chain_len vectors:
  - the first load's unload compare is controlled only by pat_mask (normally 0);
  - the final block is unload-only, and pat_si is don't-care there.
- Compare uses so in the accept cycle, before the shift edge.
- err_count adds 1 per failing vector (not per chain) and saturates at all-ones.
- first_fail_* are written once, on the first failing vector, and are registered. They are visible the cycle after the accept.
- The compared pattern number is the pattern being unloaded:
  - pattern_number-1 during SHIFT;
  - a failing vector while pattern_number==0 records first_fail_pat=0.
- abort in any non-IDLE state -> DONE next cycle; any in-flight accept in that cycle still completes and compares. abort in IDLE is ignored.
- start while busy is ignored.
- hreset mid-run: immediate return to IDLE with all outputs 0 on the next edge. No done pulse is emitted.
- Counter widths: vector_number compares against cfg_chain_len-1. There is no wrap within a run, because the config is bounded by LEN_W/PAT_W.

Decomposition:
- Package scan_player_pkg: FSM state enum (IDLE, SETUP, SHIFT, CAPTURE, DONE), SETUP_CYCLES=2 constant, saturating-increment function.
- One sub-module, scan_compare_unit: masked XOR, fail flag, saturating err_count, first-fail capture registers.

Test Plan:
- NCHAINS=4, len=3, num_pat=1, all masks 0 except the final unload (mask=4'hF, so==exp) -> 6 accepts, 1 capture, err_count=0, done one cycle after the 6th accept, Test_Se low only in capture.
- Same setup, so[2] forced wrong on final-unload vector 1 -> err_count=1, first_fail_pat=0, first_fail_vec=1, first_fail_chain=4'b0100.
- pat_valid deasserted 5 cycles mid-SHIFT -> scan_clk_en=0 and Test_Se=1 for those 5 cycles; vector_number frozen; total run +5 cycles.
- Force a miscompare on every vector with ERR_W=2 -> err_count saturates at 3; first_fail unchanged after the first miss.
- abort asserted on the 2nd SHIFT accept -> that vector is compared, done pulses next cycle, Test_Mode/Test_Se=0, busy=0.
- hreset during CAPTURE -> next cycle all outputs 0, no done pulse, state IDLE; a subsequent start runs normally with cleared counters.
